// File: rtl/lc3_mem_arb.sv
// Round-robin arbiter between the CPU and a DMA master for the single LC-3 memory port.
// Each grant runs WAIT_CYC access cycles, then a one-cycle ready pulse; requests are sampled only in IDLE.
module lc3_mem_arb #(
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic [15:0] dma_rdata,
  output logic        dma_ready,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        cpu_gnt,
  output logic        dma_gnt
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic       OWN_CPU  = 1'b0;
  localparam logic       OWN_DMA  = 1'b1;
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] crd_q, crd_d;
  logic [15:0] drd_q, drd_d;
  logic        pick_dma;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_CPU;
      last_q  <= OWN_DMA;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      crd_q   <= 16'h0000;
      drd_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      crd_q   <= crd_d;
      drd_q   <= drd_d;
    end
  end

  // On a tie the requester that did not own the previous access wins.
  assign pick_dma = dma_req && (!cpu_req || (last_q == OWN_CPU));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    crd_d   = crd_q;
    drd_d   = drd_q;
    case (state_q)
      IDLE: begin
        if (cpu_req || dma_req) begin
          owner_d = pick_dma;
          we_d    = pick_dma ? dma_we    : cpu_we;
          addr_d  = pick_dma ? dma_addr  : cpu_addr;
          wdata_d = pick_dma ? dma_wdata : cpu_wdata;
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (owner_q == OWN_DMA) drd_d = mem_rdata;
            else                    crd_d = mem_rdata;
          end
          last_d  = owner_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_cs    = (state_q == ACCESS);
  assign mem_we    = mem_cs && we_q;
  assign mem_addr  = mem_cs ? addr_q  : 16'h0000;
  assign mem_wdata = mem_cs ? wdata_q : 16'h0000;
  assign cpu_gnt   = (state_q != IDLE) && (owner_q == OWN_CPU);
  assign dma_gnt   = (state_q != IDLE) && (owner_q == OWN_DMA);
  assign cpu_ready = (state_q == DONE) && (owner_q == OWN_CPU);
  assign dma_ready = (state_q == DONE) && (owner_q == OWN_DMA);
  assign cpu_rdata = crd_q;
  assign dma_rdata = drd_q;

endmodule

// File: tb/tb_lc3_mem_arb.sv
// Bench for lc3_mem_arb: vector table, corner-case sequences, then random traffic
// checked against a transaction-level model of the arbitration and timing rules.
module tb_lc3_mem_arb;
  localparam int W = 2;

  logic        clk, rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ready, dma_ready, mem_cs, mem_we, cpu_gnt, dma_gnt;

  logic [15:0] mem [0:65535];
  logic [15:0] ref_mem [0:63];
  int total = 0;
  int bad = 0;

  lc3_mem_arb #(.WAIT_CYC(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ready(dma_ready),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt)
  );

  assign mem_rdata = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cr, cw;
    logic [15:0] ca, cd;
    logic        dr, dw;
    logic [15:0] da, dd;
    logic [69:0] exp;
  } vec_t;

  vec_t vt [20];

  function automatic logic [69:0] mkexp(logic cs, logic we, logic [15:0] a, logic [15:0] wd,
                                        logic cg, logic dg, logic crdy, logic drdy,
                                        logic [15:0] crd, logic [15:0] drd);
    return {cs, we, a, wd, cg, dg, crdy, drdy, crd, drd};
  endfunction

  function automatic vec_t mkrow(logic cr, logic cw, logic [15:0] ca, logic [15:0] cd,
                                 logic dr, logic dw, logic [15:0] da, logic [15:0] dd,
                                 logic [69:0] e);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.exp = e;
    return v;
  endfunction

  function automatic logic [69:0] obs();
    return {mem_cs, mem_we, mem_addr, mem_wdata, cpu_gnt, dma_gnt,
            cpu_ready, dma_ready, cpu_rdata, dma_rdata};
  endfunction

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory writes happen mid-cycle while mem_cs/mem_we are stable.
  task automatic tick();
    @(negedge clk);
    if (mem_cs && mem_we) mem[mem_addr] = mem_wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                       input logic dr, input logic dw, input logic [15:0] da, input logic [15:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    check("reset_state", obs(), 70'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] e_crd, e_drd, m_addr, m_wd, m_rd;
    logic        m_own, m_we, last;
    int          g;

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[16'h3000] = 16'hBEEF;
    mem[16'h5000] = 16'hCAFE;

    // ---- table-driven vectors ----
    vt[0]  = mkrow(1,0,16'h3000,0, 0,0,0,0, mkexp(1,0,16'h3000,0,1,0,0,0,0,0));
    vt[1]  = mkrow(0,0,0,0, 0,0,0,0,          mkexp(1,0,16'h3000,0,1,0,0,0,0,0));
    vt[2]  = mkrow(0,0,0,0, 0,0,0,0,          mkexp(0,0,0,0,1,0,1,0,16'hBEEF,0));
    vt[3]  = mkrow(0,0,0,0, 0,0,0,0,          mkexp(0,0,0,0,0,0,0,0,16'hBEEF,0));
    vt[4]  = mkrow(1,1,16'h4000,16'h1234, 0,0,0,0, mkexp(1,1,16'h4000,16'h1234,1,0,0,0,16'hBEEF,0));
    vt[5]  = mkrow(1,0,16'h1111,16'h5555, 0,0,0,0, mkexp(1,1,16'h4000,16'h1234,1,0,0,0,16'hBEEF,0));
    vt[6]  = mkrow(0,0,0,0, 0,0,0,0,          mkexp(0,0,0,0,1,0,1,0,16'hBEEF,0));
    vt[7]  = mkrow(0,0,0,0, 0,0,0,0,          mkexp(0,0,0,0,0,0,0,0,16'hBEEF,0));
    vt[8]  = mkrow(0,0,0,0, 1,0,16'h5000,0,   mkexp(1,0,16'h5000,0,0,1,0,0,16'hBEEF,0));
    vt[9]  = mkrow(0,0,0,0, 0,0,0,0,          mkexp(1,0,16'h5000,0,0,1,0,0,16'hBEEF,0));
    vt[10] = mkrow(0,0,0,0, 0,0,0,0,          mkexp(0,0,0,0,0,1,0,1,16'hBEEF,16'hCAFE));
    vt[11] = mkrow(0,0,0,0, 1,1,16'h5001,16'h0F0F, mkexp(0,0,0,0,0,0,0,0,16'hBEEF,16'hCAFE));
    vt[12] = mkrow(0,0,0,0, 1,1,16'h5001,16'h0F0F, mkexp(1,1,16'h5001,16'h0F0F,0,1,0,0,16'hBEEF,16'hCAFE));
    vt[13] = mkrow(0,0,0,0, 1,1,16'h5001,16'h0F0F, mkexp(1,1,16'h5001,16'h0F0F,0,1,0,0,16'hBEEF,16'hCAFE));
    vt[14] = mkrow(0,0,0,0, 1,1,16'h5001,16'h0F0F, mkexp(0,0,0,0,0,1,0,1,16'hBEEF,16'hCAFE));
    vt[15] = mkrow(0,0,0,0, 1,0,16'h5001,0,   mkexp(0,0,0,0,0,0,0,0,16'hBEEF,16'hCAFE));
    vt[16] = mkrow(0,0,0,0, 1,0,16'h5001,0,   mkexp(1,0,16'h5001,0,0,1,0,0,16'hBEEF,16'hCAFE));
    vt[17] = mkrow(0,0,0,0, 0,0,0,0,          mkexp(1,0,16'h5001,0,0,1,0,0,16'hBEEF,16'hCAFE));
    vt[18] = mkrow(0,0,0,0, 0,0,0,0,          mkexp(0,0,0,0,0,1,0,1,16'hBEEF,16'h0F0F));
    vt[19] = mkrow(0,0,0,0, 0,0,0,0,          mkexp(0,0,0,0,0,0,0,0,16'hBEEF,16'h0F0F));

    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(vt[i].cr, vt[i].cw, vt[i].ca, vt[i].cd, vt[i].dr, vt[i].dw, vt[i].da, vt[i].dd);
      tick();
      check($sformatf("vec%0d", i), obs(), vt[i].exp);
    end
    check("cpu_write_mem", {54'd0, mem[16'h4000]}, {54'd0, 16'h1234});
    check("dma_write_mem", {54'd0, mem[16'h5001]}, {54'd0, 16'h0F0F});

    // ---- tie after reset: strict alternation CPU, DMA, CPU, DMA ----
    do_reset();
    drive(1, 0, 16'h0010, 0, 1, 0, 16'h0020, 0);
    for (int c = 1; c <= 16; c++) begin
      logic [3:0] e;
      tick();
      e[3] = (c == 3 || c == 11);
      e[2] = (c == 7 || c == 15);
      e[1] = (c >= 1 && c <= 3) || (c >= 9 && c <= 11);
      e[0] = (c >= 5 && c <= 7) || (c >= 13 && c <= 15);
      check($sformatf("tie_c%0d", c), {66'd0, cpu_ready, dma_ready, cpu_gnt, dma_gnt}, {66'd0, e});
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) tick();

    // ---- late DMA request during a CPU access ----
    drive(1, 0, 16'h0030, 0, 0, 0, 0, 0);
    tick();
    cpu_req = 1'b0;
    tick();
    dma_req = 1'b1; dma_addr = 16'h0031;
    for (int c = 3; c <= 8; c++) begin
      logic [2:0] e;
      tick();
      e[2] = (c == 3);
      e[1] = (c == 7);
      e[0] = (c >= 5 && c <= 7);
      check($sformatf("late_dma_c%0d", c), {67'd0, cpu_ready, dma_ready, dma_gnt}, {67'd0, e});
      if (c == 7) dma_req = 1'b0;
    end

    // ---- reset mid-access after a completed CPU access ----
    drive(1, 0, 16'h0040, 0, 0, 0, 0, 0);
    tick();
    cpu_req = 1'b0;
    repeat (3) tick();
    drive(0, 0, 0, 0, 1, 0, 16'h0041, 0);
    tick();
    dma_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("reset_mid_access", obs(), 70'd0);
    tick();
    check("reset_held", obs(), 70'd0);
    rst_n = 1'b1;
    drive(1, 0, 16'h0042, 0, 1, 0, 16'h0043, 0);
    for (int c = 1; c <= 3; c++) begin
      logic [3:0] e;
      tick();
      if (c == 1) drive(0, 0, 0, 0, 0, 0, 0, 0);
      e = {(c == 3), 1'b0, 1'b1, 1'b0};
      check($sformatf("post_reset_c%0d", c), {66'd0, cpu_ready, dma_ready, cpu_gnt, dma_gnt}, {66'd0, e});
    end
    repeat (2) tick();

    // ---- random traffic against a transaction-level model ----
    do_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
    e_crd = 16'h0000; e_drd = 16'h0000;
    m_addr = 0; m_wd = 0; m_rd = 0; m_own = 0; m_we = 0;
    last = 1'b1;
    g = -1000;
    for (int c = 0; c < 3000; c++) begin
      logic acc, dn;
      logic cr, cw, dr, dw;
      logic [15:0] ca, cd, da, dd;
      acc = (c >= g + 1) && (c <= g + W);
      dn  = (c == g + W + 1);
      if (dn && !m_we) begin
        if (m_own) e_drd = m_rd;
        else       e_crd = m_rd;
      end
      check($sformatf("rand_c%0d", c), obs(),
            mkexp(acc, acc && m_we, acc ? m_addr : 16'h0, acc ? m_wd : 16'h0,
                  (acc || dn) && !m_own, (acc || dn) && m_own,
                  dn && !m_own, dn && m_own, e_crd, e_drd));
      cr = ($urandom_range(0, 1) == 1); cw = ($urandom_range(0, 2) == 0);
      dr = ($urandom_range(0, 1) == 1); dw = ($urandom_range(0, 2) == 0);
      ca = 16'($urandom_range(0, 63)); cd = 16'($urandom);
      da = 16'($urandom_range(0, 63)); dd = 16'($urandom);
      drive(cr, cw, ca, cd, dr, dw, da, dd);
      if ((c >= g + W + 2) && (cr || dr)) begin
        m_own  = dr && (!cr || !last);
        m_we   = m_own ? dw : cw;
        m_addr = m_own ? da : ca;
        m_wd   = m_own ? dd : cd;
        last   = m_own;
        g      = c;
        if (m_we) ref_mem[m_addr[5:0]] = m_wd;
        else      m_rd = ref_mem[m_addr[5:0]];
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lc3_mem_arb.md
# lc3_mem_arb

Two-requester memory port arbiter and access sequencer for the LC-3 system. It sits between the single synchronous memory and two requesters: the CPU datapath (driven by the control FSM's `mio_en`/`r_w`) and a DMA/peripheral master. It grants the memory round-robin and runs a fixed wait-state access. It returns a one-cycle `ready` pulse with read data to the requester that owns the access.

## Interface
- `WAIT_CYC`, default 2: memory access cycles per transfer, legal range 1..15.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cpu_req`  in  1  CPU access request (from `mio_en`).
- `cpu_we`  in  1  CPU write enable (from `r_w`); 1 = write.
- `cpu_addr`  in  16  CPU address (MAR).
- `cpu_wdata`  in  16  CPU write data (MDR).
- `cpu_rdata`  out  16  CPU read data; registered.
- `cpu_ready`  out  1  CPU access-complete pulse.
- `dma_req`, `dma_we`, `dma_addr[15:0]`, `dma_wdata[15:0]`  in: same meaning as the corresponding CPU signals, for the DMA requester.
- `dma_rdata`  out  16  DMA read data; registered.
- `dma_ready`  out  1  DMA access-complete pulse.
- `mem_cs`  out  1  memory chip select.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  16  memory address.
- `mem_wdata`  out  16  memory write data.
- `mem_rdata`  in  16  memory read data; must be valid in the last access cycle.
- `cpu_gnt`, `dma_gnt`  out  1  current owner status.

## Operation
- The FSM has three states: IDLE, ACCESS, DONE. The reset state is IDLE.
- **IDLE**
  - If any request is present, latch the winner's we/addr/wdata into internal registers, set the owner, load the wait counter with WAIT_CYC-1, and go to ACCESS.
  - With no request, stay in IDLE.
- **Arbitration (IDLE only)**
  - Only one request present: that requester wins.
  - Both present: the requester that was *not* the last owner wins.
  - The `last_owner` register resets to DMA, so the CPU wins the first tie.
- **ACCESS**
  - `mem_cs`=1, `mem_we`=latched we, and `mem_addr`/`mem_wdata` = latched values, held stable for the whole state.
  - The counter decrements each cycle. When the counter is 0, capture `mem_rdata` into the owner's rdata register (read accesses only), update `last_owner`, and go to DONE.
- **DONE**
  - The owner's ready signal is 1 for exactly one cycle; `mem_cs`=0.
  - The next state is IDLE unconditionally.
- Requester inputs are sampled only in IDLE. Changes to req or its attributes after the grant are ignored, and the access completes normally. A request dropped mid-access still completes and still produces its ready pulse.
- A req still high in the IDLE cycle after the ready pulse is treated as a new access.
- Write accesses leave that requester's rdata register unchanged. Each rdata register holds its value until that requester's next read completes.
- `cpu_gnt`/`dma_gnt` = owner, asserted in ACCESS and DONE; both are 0 in IDLE.
- The counter is 4 bits wide. WAIT_CYC outside 1..15 is unsupported.

## Timing
- **Reset values:** all outputs 0, both rdata registers 0x0000, state IDLE, counter 0, `last_owner`=DMA.
- Reset applies asynchronously at any time, including mid-access. The aborted access produces no ready pulse, and `mem_cs` drops immediately.
- **Latency:** request sampled high at edge 0.
  - ACCESS occupies cycles 1..WAIT_CYC.
  - The ready pulse occurs in cycle WAIT_CYC+1, with rdata already valid in that cycle.
  - The next IDLE is cycle WAIT_CYC+2.
- **Throughput:** one access per WAIT_CYC+2 cycles. Under continuous contention, CPU and DMA strictly alternate.
- A request from the non-owner during ACCESS or DONE waits. It is granted at the following IDLE if it is still asserted there.
- `mem_cs` is high for exactly WAIT_CYC consecutive cycles per access. `mem_we` is never high while `mem_cs` is low.

## Test plan
- **CPU read:** WAIT_CYC=2, memory[0x3000]=0xBEEF, `cpu_req`=1 with `cpu_we`=0 and `cpu_addr`=0x3000 at cycle 0. Expected: `mem_cs` high in cycles 1–2 with `mem_addr`=0x3000; `cpu_ready` pulses in cycle 3 with `cpu_rdata`=0xBEEF; `dma_ready` stays 0.
- **CPU write:** `cpu_we`=1, addr 0x4000, wdata 0x1234. Expected: `mem_we`=1 for 2 cycles; afterwards memory[0x4000]=0x1234; `cpu_rdata` unchanged; `cpu_ready` pulses once.
- **Tie after reset:** `cpu_req` and `dma_req` both held high from cycle 0. Expected grant order CPU, DMA, CPU, DMA, with ready pulses in cycles 3, 7, 11, 15.
- **Late DMA request:** DMA requests in cycle 2 of a CPU access. Expected: DMA is granted in cycle 4 (IDLE) and `dma_ready` pulses in cycle 7.
- **Dropped request:** `cpu_req` pulled low in cycle 1 of an access. Expected: the access still completes and `cpu_ready` pulses in cycle 3.
- **Reset mid-access:** `rst_n` driven low in cycle 2 of an access. Expected: all outputs 0 immediately and no ready pulse; after release, a tie is granted to the CPU.
